rv_fetch_prefetch: RTL
======================

// Module: rv_fetch_prefetch
// PURPOSE
//  Sequential instruction prefetcher between the fetch stage and a pipelined Wishbone instruction bus.
//  - Serves the fetch stage's single-word {cyc, addr} requests.
//  - Speculatively streams consecutive words into a small in-order buffer.
//  - Restarts the stream on a non-sequential address or on a flush.
//  - Discards in-flight responses that belong to a killed stream.
// PARAMETERS
//  DEPTH            4   buffer entries; power of two, >= 2
//  MAX_OUTSTANDING  2   maximum bus requests in flight; 1..DEPTH
// PORTS
//  i_clk            in   1   single clock, rising edge
//  i_reset          in   1   asynchronous, active-high reset
//  i_flush          in   1   kill stream: buffer cleared, live in-flight requests become stale
//  i_cyc            in   1   fetch requests the word at i_addr
//  i_addr           in   32  fetch word address; bits[1:0] ignored
//  o_ack            out  1   i_addr accepted this cycle; data appears on o_instruction next cycle
//  o_instruction    out  32  registered word; held until the next o_ack
//  o_err            out  1   registered bus-error flag; accompanies o_instruction
//  o_wb_cyc         out  1   bus cycle active
//  o_wb_stb         out  1   request strobe
//  o_wb_adr         out  32  request address; always word-aligned
//  i_wb_stall       in   1   slave cannot accept the request this cycle
//  i_wb_ack         in   1   read data valid, in request order
//  i_wb_err         in   1   response terminated with error; counts as a response
//  i_wb_dat         in   32  read data
// BEHAVIOUR
//  Reset: all outputs 0; buffer empty; stream_valid=0; live=0; stale=0; req_addr=0.
//  State:
//  - base: word address of the oldest entry, buffered or in flight.
//  - req_addr: next address to issue.
//  - cnt: number of buffered entries.
//  - live: in-flight requests of the current stream.
//  - stale: in-flight requests of killed streams.
//  Hit: i_cyc & cnt>0 & base==i_addr[31:2] -> o_ack=1, combinational from registered state only.
//    - Next edge: o_instruction/o_err <= head; pop; base += 1.
//  Wait: i_cyc & cnt==0 & live>0 & base==i_addr -> o_ack=0; hold.
//  Miss: i_cyc & (!stream_valid | (base!=i_addr & (cnt>0|live>0)) | (cnt==0 & live==0 & base!=i_addr)).
//    - Restart: base=req_addr=i_addr[31:2]; cnt=0; stream_valid=1.
//    - stale_next = stale + live - resp; live_next = 0.
//    - No strobe in the restart cycle.
//  i_flush: same clearing as restart, but stream_valid=0. Flush has priority over hit and miss;
//    o_ack=0 in that cycle.
//  Issue: o_wb_stb = stream_valid & !restart & !flush & (cnt+live) < DEPTH & live < MAX_OUTSTANDING.
//    - o_wb_stb is registered (Wishbone pipelined rules).
//    - o_wb_adr = {req_addr, 2'b00}; stb/adr held stable while i_wb_stall.
//    - Accepted (stb & !stall): req_addr += 1 (32-bit wrap FFFF_FFFC -> 0); live += 1.
//    - Accounting uses the accepted count. If a flush or restart hits while stb is pending, stb
//      drops next cycle. The pending request counts as stale only if it was accepted
//      (!i_wb_stall) that cycle.
//  Response (i_wb_ack | i_wb_err):
//    - stale > 0 -> drop; stale -= 1.
//    - Otherwise push {i_wb_dat, i_wb_err}; live -= 1. Error data is forced to 0.
//  o_wb_cyc = o_wb_stb | live>0 | stale>0; low when idle.
//  Simultaneous events:
//  - pop + push in one cycle: cnt unchanged.
//  - Response arriving with stale==0 in a restart cycle is dropped and counted against live.
//  - Hit and push on an empty buffer in the same cycle is impossible (hit needs cnt>0).
//    Data is available the cycle after the push.
//  Capacity: cnt+live+pending <= DEPTH, so the buffer never overflows. A push into a full
//    buffer is an assertion failure.
//  Mid-operation reset: state clears immediately. Responses from before reset are not
//    tracked; the bus slave is reset together with this block.
// STRUCTURE
//  - rv_fetch_pkg: typedef pf_entry_t {logic[31:0] data; logic err;}; localparam WORD_BITS=30.
//  - Sub-module rv_prefetch_fifo: DEPTH-entry circular FIFO of pf_entry_t.
//    Ports: push, pop, clear, head, cnt; pointer wrap on power-of-two DEPTH.
//  - Top level holds the counters, base/req_addr, hit/miss decode and the Wishbone issue logic.
// TESTING
//  1 Reset, i_cyc=1, addr=0x100, zero-wait slave -> strobes 0x100,0x104,0x108,0x10C;
//    o_ack on the cycle head==0x100; o_instruction=mem[0x100] next cycle.
//  2 Sequential fetch 0x100..0x11C, slave stall every other cycle -> acks in order;
//    o_wb_adr stable during stall; never more than 2 outstanding.
//  3 Branch: with 2 in flight from 0x108, fetch requests 0x400 -> restart; 2 responses dropped
//    (stale 2->0); first delivered word = mem[0x400].
//  4 i_flush while stb is stalled -> stb drops; that request is not counted; no ack until i_cyc;
//    next i_cyc addr=0x200 restarts correctly.
//  5 i_wb_err on 0x104 -> o_err=1 with o_instruction=0 for that word; neighbouring words o_err=0.
//  6 Wrap: stream from 0xFFFF_FFF8 -> issues 0xFFFF_FFFC, then 0x0000_0000.
//    Reset asserted mid-burst -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the sequential instruction prefetcher.
package rv_fetch_pkg;

    localparam int WORD_BITS = 30;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } pf_entry_t;

endpackage

// File: rtl/rv_prefetch_fifo.sv
// In-order circular buffer of prefetched words; clear drops every entry at once.
module rv_prefetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      clear_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  pf_entry_t push_entry_i,
    output pf_entry_t head_o,
    output logic [AW:0] cnt_o
);

    pf_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset: cnt gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

    full_push_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && !clear_i && cnt_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/rv_fetch_prefetch.sv
// Sequential instruction prefetcher between the fetch stage and a pipelined Wishbone bus.
module rv_fetch_prefetch
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_cyc,
    input  logic [31:0] i_addr,
    output logic        o_ack,
    output logic [31:0] o_instruction,
    output logic        o_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_BITS-1:0] base_q, base_d, req_addr_q, req_addr_d, addr_w;
    logic                 stream_valid_q, stream_valid_d;
    logic                 stb_q, stb_d;
    logic [CNT_W-1:0]     live_q, live_d, stale_q, stale_d, live_after;
    logic [31:0]          instr_q;
    logic                 err_q;
    logic [AW:0]          cnt_w, cnt_after;
    logic [CNT_W:0]       occ;
    pf_entry_t            head_w, push_entry_w;
    logic                 hit, restart, kill, accepted, resp, resp_stale, resp_live, push;
    logic                 unused_addr_lsb;

    assign addr_w          = i_addr[31:2];
    assign unused_addr_lsb = ^i_addr[1:0];

    assign hit     = i_cyc && !i_flush && stream_valid_q && (cnt_w != '0) && (base_q == addr_w);
    assign restart = i_cyc && !i_flush && (!stream_valid_q || (base_q != addr_w));
    assign kill    = i_flush || restart;

    // Bus handshake: a request transfers on stb & !stall; ack|err is one response, in request order.
    assign accepted   = stb_q && !i_wb_stall;
    assign resp       = i_wb_ack || i_wb_err;
    assign resp_stale = resp && (stale_q != '0);
    assign resp_live  = resp && (stale_q == '0);
    assign push       = resp_live && !kill;

    assign push_entry_w.data = i_wb_err ? 32'h0 : i_wb_dat;
    assign push_entry_w.err  = i_wb_err;

    always_comb begin
        live_after     = live_q + CNT_W'(accepted) - CNT_W'(resp_live);
        base_d         = base_q;
        req_addr_d     = req_addr_q;
        stream_valid_d = stream_valid_q;
        live_d         = live_after;
        stale_d        = stale_q - CNT_W'(resp_stale);
        if (accepted) req_addr_d = req_addr_q + WORD_BITS'(1);
        if (hit)      base_d     = base_q + WORD_BITS'(1);
        if (kill) begin
            // Everything still on the bus for the old stream, including a strobe taken this cycle.
            live_d  = '0;
            stale_d = stale_q - CNT_W'(resp_stale) + live_after;
        end
        if (restart) begin
            base_d         = addr_w;
            req_addr_d     = addr_w;
            stream_valid_d = 1'b1;
        end
        if (i_flush) stream_valid_d = 1'b0;

        cnt_after = kill ? '0 : cnt_w + (AW+1)'(push) - (AW+1)'(hit);
        occ       = (CNT_W+1)'(cnt_after) + {1'b0, live_d};
        if (stb_q && i_wb_stall && !kill) begin
            stb_d = 1'b1;
        end else begin
            stb_d = stream_valid_d && !kill && (occ < (CNT_W+1)'(DEPTH))
                    && (live_d < CNT_W'(MAX_OUTSTANDING));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            base_q         <= '0;
            req_addr_q     <= '0;
            stream_valid_q <= 1'b0;
            stb_q          <= 1'b0;
            live_q         <= '0;
            stale_q        <= '0;
            instr_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            base_q         <= base_d;
            req_addr_q     <= req_addr_d;
            stream_valid_q <= stream_valid_d;
            stb_q          <= stb_d;
            live_q         <= live_d;
            stale_q        <= stale_d;
            if (hit) begin
                instr_q <= head_w.data;
                err_q   <= head_w.err;
            end
        end
    end

    rv_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (i_clk),
        .rst_i        (i_reset),
        .clear_i      (kill),
        .push_i       (push),
        .pop_i        (hit),
        .push_entry_i (push_entry_w),
        .head_o       (head_w),
        .cnt_o        (cnt_w)
    );

    assign o_ack         = hit;
    assign o_instruction = instr_q;
    assign o_err         = err_q;
    assign o_wb_stb      = stb_q;
    assign o_wb_adr      = {req_addr_q, 2'b00};
    assign o_wb_cyc      = stb_q || (live_q != '0) || (stale_q != '0);

endmodule
